// File: rtl/prog_counter.sv
// prog_counter: program counter with relative branch, absolute jump,
// call/return through a small return-address stack, and a RUN/HALT/TRAP
// control FSM. Illegal control requests trap with a cause code; running
// off the end of the program halts.
module prog_counter #(
    parameter int PC_W      = 10,
    parameter int PC_LIMIT  = 63,
    parameter int OFF_W     = 8,
    parameter int RAS_DEPTH = 4
) (
    input  logic                           CLK,
    input  logic                           init_n,
    input  logic                           start,
    input  logic                           stall,
    input  logic                           branch_en,
    input  logic signed [OFF_W-1:0]        branch_off,
    input  logic                           jump_en,
    input  logic                           call_en,
    input  logic                           ret_en,
    input  logic [PC_W-1:0]                jump_tgt,
    output logic [PC_W-1:0]                PC,
    output logic                           halt,
    output logic                           trap,
    output logic [2:0]                     trap_code,
    output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count
);

    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam int IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [PC_W-1:0]  LIMIT = PC_W'(PC_LIMIT);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(RAS_DEPTH);

    localparam logic [2:0] TC_NONE  = 3'd0;
    localparam logic [2:0] TC_RANGE = 3'd1;  // target outside 0..PC_LIMIT
    localparam logic [2:0] TC_OVF   = 3'd2;  // call with a full stack
    localparam logic [2:0] TC_UNF   = 3'd3;  // return with an empty stack
    localparam logic [2:0] TC_MULTI = 3'd4;  // more than one control request

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HALT = 2'd1,
        TRAP = 2'd2
    } state_t;

    state_t                   state;
    state_t                   state_d;
    logic [PC_W-1:0]          pc_d;
    logic [PC_W-1:0]          pc_inc;
    logic [CNT_W-1:0]         cnt_d;
    logic [2:0]               code_d;
    logic                     push;
    logic [PC_W-1:0]          ras [RAS_DEPTH];
    logic signed [PC_W:0]     br_sum;
    logic                     br_bad;
    logic [IDX_W-1:0]         top_idx;
    logic [IDX_W-1:0]         push_idx;

    // The return address is PC+1 and may be PC_LIMIT+1; returning there
    // simply halts on the following sequential step.
    assign pc_inc   = PC + 1'b1;
    // One extra bit keeps the sign so backward branches past 0 are caught.
    assign br_sum   = $signed({1'b0, PC}) + (PC_W+1)'(branch_off);
    assign br_bad   = br_sum[PC_W] || (br_sum[PC_W-1:0] > LIMIT);
    assign top_idx  = IDX_W'(ras_count - 1'b1);
    assign push_idx = IDX_W'(ras_count);

    assign halt = (state != RUN);
    assign trap = (state == TRAP);

    // Next-state decode: control requests in RUN, restart in HALT/TRAP.
    always_comb begin
        state_d = state;
        pc_d    = PC;
        cnt_d   = ras_count;
        code_d  = trap_code;
        push    = 1'b0;
        case (state)
            RUN: begin
                if (!stall) begin
                    if (!$onehot0({branch_en, jump_en, call_en, ret_en})) begin
                        state_d = TRAP;
                        code_d  = TC_MULTI;
                    end else if (branch_en) begin
                        if (br_bad) begin
                            state_d = TRAP;
                            code_d  = TC_RANGE;
                        end else begin
                            pc_d = br_sum[PC_W-1:0];
                        end
                    end else if (jump_en) begin
                        if (jump_tgt > LIMIT) begin
                            state_d = TRAP;
                            code_d  = TC_RANGE;
                        end else begin
                            pc_d = jump_tgt;
                        end
                    end else if (call_en) begin
                        // A full stack outranks a bad target.
                        if (ras_count == FULL) begin
                            state_d = TRAP;
                            code_d  = TC_OVF;
                        end else if (jump_tgt > LIMIT) begin
                            state_d = TRAP;
                            code_d  = TC_RANGE;
                        end else begin
                            push  = 1'b1;
                            cnt_d = ras_count + 1'b1;
                            pc_d  = jump_tgt;
                        end
                    end else if (ret_en) begin
                        if (ras_count == '0) begin
                            state_d = TRAP;
                            code_d  = TC_UNF;
                        end else begin
                            pc_d  = ras[top_idx];
                            cnt_d = ras_count - 1'b1;
                        end
                    end else if (PC < LIMIT) begin
                        pc_d = pc_inc;
                    end else begin
                        state_d = HALT;
                        code_d  = TC_NONE;
                    end
                end
            end
            HALT, TRAP: begin
                if (start) begin
                    state_d = RUN;
                    pc_d    = '0;
                    cnt_d   = '0;
                    code_d  = TC_NONE;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Control state and PC, cleared immediately by the asynchronous reset.
    always_ff @(posedge CLK or negedge init_n) begin
        if (!init_n) begin
            state     <= RUN;
            PC        <= '0;
            ras_count <= '0;
            trap_code <= TC_NONE;
        end else begin
            state     <= state_d;
            PC        <= pc_d;
            ras_count <= cnt_d;
            trap_code <= code_d;
        end
    end

    // Return-address storage; contents are meaningless above ras_count.
    always_ff @(posedge CLK) begin
        if (push) begin
            ras[push_idx] <= pc_inc;
        end
    end

endmodule

// File: tb/tb_prog_counter.sv
// tb_prog_counter: scenario tasks drive a table of per-cycle stimulus,
// queue the architecturally expected state and compare after each edge.
module tb_prog_counter;

    logic             CLK = 1'b0;
    logic             init_n = 1'b1;
    logic             start = 1'b0;
    logic             stall = 1'b0;
    logic             branch_en = 1'b0;
    logic [7:0]       branch_off = '0;
    logic             jump_en = 1'b0;
    logic             call_en = 1'b0;
    logic             ret_en = 1'b0;
    logic [9:0]       jump_tgt = '0;
    logic [9:0]       PC;
    logic             halt;
    logic             trap;
    logic [2:0]       trap_code;
    logic [2:0]       ras_count;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [9:0] pc;
        logic       halt;
        logic       trap;
        logic [2:0] code;
        logic [2:0] cnt;
    } snap_t;

    typedef struct packed {
        logic       st;
        logic       sl;
        logic       b;
        logic [7:0] off;
        logic       j;
        logic       c;
        logic       r;
        logic [9:0] tgt;
        snap_t      exp;
    } stim_t;

    snap_t sb[$];

    prog_counter #(
        .PC_W(10), .PC_LIMIT(63), .OFF_W(8), .RAS_DEPTH(4)
    ) dut (
        .CLK(CLK), .init_n(init_n), .start(start), .stall(stall),
        .branch_en(branch_en), .branch_off(branch_off), .jump_en(jump_en),
        .call_en(call_en), .ret_en(ret_en), .jump_tgt(jump_tgt),
        .PC(PC), .halt(halt), .trap(trap), .trap_code(trap_code),
        .ras_count(ras_count)
    );

    always #5 CLK = ~CLK;

    function automatic snap_t e(input int pc, input int h, input int t, input int code, input int cnt);
        snap_t s;
        s.pc = pc[9:0]; s.halt = h[0]; s.trap = t[0]; s.code = code[2:0]; s.cnt = cnt[2:0];
        return s;
    endfunction
    function automatic snap_t run(input int pc, input int cnt); return e(pc, 0, 0, 0, cnt); endfunction
    function automatic snap_t hlt(input int pc, input int cnt); return e(pc, 1, 0, 0, cnt); endfunction
    function automatic snap_t trp(input int pc, input int code, input int cnt); return e(pc, 1, 1, code, cnt); endfunction

    function automatic stim_t mk(input int st, input int sl, input int b, input int off, input int j,
                                 input int c, input int r, input int tgt, input snap_t x);
        stim_t s;
        s.st = st[0]; s.sl = sl[0]; s.b = b[0]; s.off = off[7:0]; s.j = j[0];
        s.c = c[0]; s.r = r[0]; s.tgt = tgt[9:0]; s.exp = x;
        return s;
    endfunction
    function automatic stim_t none(input snap_t x); return mk(0, 0, 0, 0, 0, 0, 0, 0, x); endfunction
    function automatic stim_t jmp(input int tgt, input snap_t x); return mk(0, 0, 0, 0, 1, 0, 0, tgt, x); endfunction
    function automatic stim_t br(input int off, input snap_t x); return mk(0, 0, 1, off, 0, 0, 0, 0, x); endfunction
    function automatic stim_t cal(input int tgt, input snap_t x); return mk(0, 0, 0, 0, 0, 1, 0, tgt, x); endfunction
    function automatic stim_t rt(input snap_t x); return mk(0, 0, 0, 0, 0, 0, 1, 0, x); endfunction
    function automatic stim_t go(input snap_t x); return mk(1, 0, 0, 0, 0, 0, 0, 0, x); endfunction

    function automatic snap_t snap();
        return {PC, halt, trap, trap_code, ras_count};
    endfunction

    function automatic string fmt(input snap_t s);
        return $sformatf("pc=%0d halt=%0b trap=%0b code=%0d cnt=%0d", s.pc, s.halt, s.trap, s.code, s.cnt);
    endfunction

    // Apply one row of stimulus and queue the state it must produce.
    task automatic drive(input stim_t s);
        start = s.st; stall = s.sl; branch_en = s.b; branch_off = s.off;
        jump_en = s.j; call_en = s.c; ret_en = s.r; jump_tgt = s.tgt;
        sb.push_back(s.exp);
    endtask

    task automatic pulse_reset();
        drive_idle();
        init_n = 1'b0;
        #2;
        init_n = 1'b1;
    endtask

    task automatic drive_idle();
        start = 0; stall = 0; branch_en = 0; branch_off = '0;
        jump_en = 0; call_en = 0; ret_en = 0; jump_tgt = '0;
    endtask

    task automatic test_reset();
        snap_t got;
        #1 init_n = 1'b0;
        #1;
        got = snap(); n_chk++;
        if (got !== run(0, 0)) begin
            n_fail++; $display("FAIL reset_async: got %s required %s", fmt(got), fmt(run(0, 0)));
        end
        @(posedge CLK); #1;
        got = snap(); n_chk++;
        if (got !== run(0, 0)) begin
            n_fail++; $display("FAIL reset_held: got %s required %s", fmt(got), fmt(run(0, 0)));
        end
        init_n = 1'b1;
    endtask

    task automatic test_free_run();
        stim_t s[$];
        snap_t got, exp;
        for (int k = 1; k <= 63; k++) s.push_back(none(run(k, 0)));
        s.push_back(none(hlt(63, 0)));
        s.push_back(none(hlt(63, 0)));
        s.push_back(jmp(5, hlt(63, 0)));
        s.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, hlt(63, 0)));
        s.push_back(go(run(0, 0)));
        foreach (s[i]) begin
            drive(s[i]);
            @(posedge CLK); #1;
            got = snap(); exp = sb.pop_front(); n_chk++;
            if (got !== exp) begin
                n_fail++; $display("FAIL free_run[%0d]: got %s required %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_branch();
        stim_t s[$];
        snap_t got, exp;
        pulse_reset();
        s = '{jmp(20, run(20, 0)), br(-14, run(6, 0)), jmp(60, run(60, 0)), br(3, run(63, 0)),
              jmp(60, run(60, 0)), br(4, trp(60, 1, 0)), br(-14, trp(60, 1, 0)), go(run(0, 0)),
              jmp(5, run(5, 0)), br(-14, trp(5, 1, 0)), go(run(0, 0))};
        foreach (s[i]) begin
            drive(s[i]);
            @(posedge CLK); #1;
            got = snap(); exp = sb.pop_front(); n_chk++;
            if (got !== exp) begin
                n_fail++; $display("FAIL branch[%0d]: got %s required %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_bounds();
        stim_t s[$];
        snap_t got, exp;
        pulse_reset();
        s = '{jmp(63, run(63, 0)), cal(0, run(0, 1)), rt(run(64, 0)), none(hlt(64, 0)),
              go(run(0, 0)), cal(64, trp(0, 1, 0)), go(run(0, 0)), jmp(64, trp(0, 1, 0)),
              go(run(0, 0))};
        foreach (s[i]) begin
            drive(s[i]);
            @(posedge CLK); #1;
            got = snap(); exp = sb.pop_front(); n_chk++;
            if (got !== exp) begin
                n_fail++; $display("FAIL bounds[%0d]: got %s required %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_nested_calls();
        stim_t s[$];
        snap_t got, exp;
        pulse_reset();
        s = '{none(run(1, 0)), cal(10, run(10, 1)), none(run(11, 1)), cal(20, run(20, 2)),
              none(run(21, 2)), cal(30, run(30, 3)), none(run(31, 3)), cal(40, run(40, 4)),
              cal(100, trp(40, 2, 4)), rt(trp(40, 2, 4)), go(run(0, 0)),
              jmp(10, run(10, 0)), cal(20, run(20, 1)), cal(30, run(30, 2)), cal(40, run(40, 3)),
              cal(50, run(50, 4)), rt(run(41, 3)), rt(run(31, 2)), rt(run(21, 1)), rt(run(11, 0)),
              rt(trp(11, 3, 0)), go(run(0, 0))};
        foreach (s[i]) begin
            drive(s[i]);
            @(posedge CLK); #1;
            got = snap(); exp = sb.pop_front(); n_chk++;
            if (got !== exp) begin
                n_fail++; $display("FAIL nested_calls[%0d]: got %s required %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_collision();
        stim_t s[$];
        snap_t got, exp;
        pulse_reset();
        s = '{none(run(1, 0)), mk(0, 0, 1, 5, 1, 0, 0, 30, trp(1, 4, 0)), go(run(0, 0)),
              mk(0, 0, 0, 0, 0, 1, 1, 30, trp(0, 4, 0)), go(run(0, 0))};
        foreach (s[i]) begin
            drive(s[i]);
            @(posedge CLK); #1;
            got = snap(); exp = sb.pop_front(); n_chk++;
            if (got !== exp) begin
                n_fail++; $display("FAIL collision[%0d]: got %s required %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_stall_start();
        stim_t s[$];
        snap_t got, exp;
        pulse_reset();
        s = '{jmp(7, run(7, 0)), mk(0, 1, 0, 0, 0, 0, 0, 0, run(7, 0)),
              mk(0, 1, 0, 0, 1, 0, 0, 30, run(7, 0)), mk(0, 1, 0, 0, 0, 1, 0, 30, run(7, 0)),
              none(run(8, 0)), jmp(64, trp(8, 1, 0)), go(run(0, 0)), go(run(1, 0)),
              jmp(64, trp(1, 1, 0)), mk(1, 1, 0, 0, 0, 0, 0, 0, run(0, 0))};
        foreach (s[i]) begin
            drive(s[i]);
            @(posedge CLK); #1;
            got = snap(); exp = sb.pop_front(); n_chk++;
            if (got !== exp) begin
                n_fail++; $display("FAIL stall_start[%0d]: got %s required %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_async_reset();
        stim_t s[$];
        snap_t got, exp;
        pulse_reset();
        s = '{cal(10, run(10, 1)), cal(33, run(33, 2)), none(run(34, 2)), none(run(35, 2))};
        foreach (s[i]) begin
            drive(s[i]);
            @(posedge CLK); #1;
            got = snap(); exp = sb.pop_front(); n_chk++;
            if (got !== exp) begin
                n_fail++; $display("FAIL async_setup[%0d]: got %s required %s", i, fmt(got), fmt(exp));
            end
        end
        drive_idle();
        #2 init_n = 1'b0;
        #1;
        got = snap(); n_chk++;
        if (got !== run(0, 0)) begin
            n_fail++; $display("FAIL async_mid_cycle: got %s required %s", fmt(got), fmt(run(0, 0)));
        end
        @(posedge CLK); #1;
        init_n = 1'b1;
        s = '{none(run(1, 0)), jmp(64, trp(1, 1, 0))};
        foreach (s[i]) begin
            drive(s[i]);
            @(posedge CLK); #1;
            got = snap(); exp = sb.pop_front(); n_chk++;
            if (got !== exp) begin
                n_fail++; $display("FAIL async_resume[%0d]: got %s required %s", i, fmt(got), fmt(exp));
            end
        end
        drive_idle();
        #2 init_n = 1'b0;
        #1;
        got = snap(); n_chk++;
        if (got !== run(0, 0)) begin
            n_fail++; $display("FAIL async_in_trap: got %s required %s", fmt(got), fmt(run(0, 0)));
        end
        @(posedge CLK); #1;
        init_n = 1'b1;
        s = '{none(run(1, 0))};
        foreach (s[i]) begin
            drive(s[i]);
            @(posedge CLK); #1;
            got = snap(); exp = sb.pop_front(); n_chk++;
            if (got !== exp) begin
                n_fail++; $display("FAIL async_after_trap[%0d]: got %s required %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_branch();
        test_bounds();
        test_nested_calls();
        test_collision();
        test_stall_start();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_counter.md
PROG_COUNTER -- requirements
Module: prog_counter

Interface
REQ-001 SHALL have parameter PC_W, default 10, PC width in bits.
REQ-002 SHALL have parameter PC_LIMIT, default 63, last legal PC value; must be less than 2^PC_W.
REQ-003 SHALL have parameter OFF_W, default 8, signed relative-branch offset width.
REQ-004 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries; minimum 1.
REQ-005 SHALL have port CLK  input  1  the single clock; all state changes on its rising edge.
REQ-006 SHALL have port init_n  input  1  reset, asynchronous and active-low.
REQ-007 SHALL have port start  input  1  leave HALT/TRAP and restart from PC 0.
REQ-008 SHALL have port stall  input  1  hold all state this cycle.
REQ-009 SHALL have port branch_en  input  1  relative branch: PC + branch_off.
REQ-010 SHALL have port branch_off  input  OFF_W  two's-complement offset.
REQ-011 SHALL have port jump_en  input  1  absolute jump to jump_tgt.
REQ-012 SHALL have port call_en  input  1  push PC+1 and jump to jump_tgt.
REQ-013 SHALL have port ret_en  input  1  pop the RAS top into PC.
REQ-014 SHALL have port jump_tgt  input  PC_W  absolute target for jump and call.
REQ-015 SHALL have port PC  output  PC_W  current program counter.
REQ-016 SHALL have port halt  output  1  high in HALT or TRAP state.
REQ-017 SHALL have port trap  output  1  high in TRAP state only.
REQ-018 SHALL have port trap_code  output  3  cause of the last trap; 0 when none.
REQ-019 SHALL have port ras_count  output  clog2(RAS_DEPTH+1)  occupied RAS entries.

Function
REQ-020 SHALL implement three states, RUN, HALT and TRAP, with halt = (state != RUN) and trap = (state == TRAP).
REQ-021 In RUN with stall=1, SHALL hold PC, RAS, ras_count and state unchanged.
REQ-022 In RUN with stall=0, more than one of branch_en/jump_en/call_en/ret_en high SHALL enter TRAP with trap_code=4, PC held.
REQ-023 In RUN with no control high, SHALL set PC to PC+1 if PC < PC_LIMIT; otherwise SHALL enter HALT with PC held, trap_code 0.
REQ-024 Branch SHALL compute PC + sign-extended branch_off at PC_W+1 bits; if the result is negative or greater than PC_LIMIT, SHALL enter TRAP with trap_code=1 and PC held; otherwise SHALL load PC with the result.
REQ-025 Jump with jump_tgt > PC_LIMIT SHALL enter TRAP with trap_code=1; otherwise SHALL set PC to jump_tgt.
REQ-026 Call with ras_count == RAS_DEPTH SHALL enter TRAP with trap_code=2.
REQ-027 Call with jump_tgt > PC_LIMIT SHALL enter TRAP with trap_code=1; code 2 takes priority over code 1.
REQ-028 A legal call SHALL push PC+1, increment ras_count and set PC to jump_tgt in one cycle.
REQ-029 Pushed value PC+1 may equal PC_LIMIT+1; a later return to it SHALL enter HALT on the following cycle per REQ-023.
REQ-030 Ret with ras_count == 0 SHALL enter TRAP with trap_code=3.
REQ-031 A legal ret SHALL set PC to the top entry and decrement ras_count; the stack is LIFO.
REQ-032 In HALT or TRAP, SHALL ignore stall and all control inputs except start; PC, RAS and trap_code are frozen.
REQ-033 start=1 in HALT or TRAP SHALL, on the next edge, set PC=0, ras_count=0 and trap_code=0, and enter RUN; start SHALL be ignored in RUN.
REQ-034 Every transition into TRAP or HALT SHALL take effect on the same edge that evaluates the causing input; there is no extra latency.

Reset
REQ-035 init_n=0 SHALL immediately, without waiting for a clock, force PC=0, state=RUN, ras_count=0 and trap_code=0 (so halt=0 and trap=0); RAS contents are don't-care.
REQ-036 Reset asserted mid-operation, including in HALT or TRAP, SHALL override everything; on the first edge after deassertion, normal RUN behaviour resumes from PC=0.

Verification
REQ-037 Bench SHALL cover free run: release reset, no controls -> PC 0,1,...,63, then halt=1, trap=0, PC stays 63.
REQ-038 Bench SHALL cover branch: at PC=20 with branch_off=-14 -> PC=6; at PC=5 with branch_off=-14 -> trap=1, trap_code=1, PC=5.
REQ-039 Bench SHALL cover nested calls: call to 10, 20, 30, 40 from PCs 1, 11, 21, 31 -> ras_count=4; a fifth call -> trap_code=2; after start, four rets from a fresh sequence return 41, 31, 21, 11 -> PC in LIFO order.
REQ-040 Bench SHALL cover empty return and collision: ret_en at ras_count=0 -> trap_code=3; jump_en and branch_en together -> trap_code=4, PC unchanged.
REQ-041 Bench SHALL cover stall and start: stall held 3 cycles at PC=7 -> PC stays 7, then PC=8; in TRAP, start pulse -> PC=0, halt=0, trap_code=0 next cycle.
REQ-042 Bench SHALL cover asynchronous reset: drop init_n between clock edges while PC=35 with ras_count=2 -> PC=0 and ras_count=0 before the next edge.
